i2c_tx_feeder: RTL and testbench

- Upstream neighbour of the I2C slave's transmit FIFO; owns the FIFO's write_enable/write_data inputs.
- Accepts a host-side message command (length) and a valid/ready byte stream, holds one byte, and pushes bytes into the FIFO while respecting fifo_full.
- Optionally appends an 8-bit checksum byte so the I2C master can verify the read-back payload.

---
 rtl/i2c_tx_feeder_pkg.sv | 20 ++
 rtl/i2c_tx_feeder.sv | 126 ++++++++++++
 tb/tb_i2c_tx_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tx_feeder_pkg.sv
// Shared types for the I2C transmit feeder: FSM state encoding, byte width,
// and the two's-complement checksum helper.
// Latency: n/a (types only). Backpressure: n/a.
package i2c_tx_feeder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_CHKSUM = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Byte that makes (payload + checksum) mod 256 == 0.
   function automatic logic [BYTE_W-1:0] chksum_byte(input logic [BYTE_W-1:0] sum);
      return (~sum) + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_tx_feeder.sv
// Feeds host bytes into the I2C slave transmit FIFO, optionally appending a checksum.
// Latency: byte accepted in cycle N is pushed (write_enable) no earlier than N+2; max 1 byte / 2 cycles.
// Backpressure: fifo_full stalls the one-entry hold register, which drops s_ready until it drains.
// Ports: clk/n_rst; cmd_start/cmd_len/cmd_abort message control; s_valid/s_data/s_ready host
//        stream; fifo_full/write_enable/write_data FIFO side; busy/done/err status.
module i2c_tx_feeder
   import i2c_tx_feeder_pkg::*;
#(
   parameter int LEN_W     = 8,
   parameter bit CHKSUM_EN = 1'b1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cmd_start,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_abort,
   input  logic              s_valid,
   input  logic [BYTE_W-1:0] s_data,
   output logic              s_ready,
   input  logic              fifo_full,
   output logic              write_enable,
   output logic [BYTE_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e             state_q;
   logic [BYTE_W-1:0]  hold_q;
   logic               hold_vld_q;
   logic [LEN_W-1:0]   rem_q;
   logic [BYTE_W-1:0]  sum_q;
   logic               write_enable_q;
   logic [BYTE_W-1:0]  write_data_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;

   logic in_xfer;
   logic accept;
   logic push;

   assign in_xfer = (state_q == ST_STREAM) || (state_q == ST_CHKSUM);

   // Combinational so the host sees the hold slot free in the same cycle it drains.
   assign s_ready = (state_q == ST_STREAM) && !hold_vld_q && (rem_q != '0);
   assign accept  = s_valid && s_ready;

   // write_enable_q doubles as the gap flag: a push last cycle means fifo_full
   // has not yet caught up, so skip this cycle.
   assign push = in_xfer && hold_vld_q && !fifo_full && !write_enable_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= ST_IDLE;
         hold_q         <= '0;
         hold_vld_q     <= 1'b0;
         rem_q          <= '0;
         sum_q          <= '0;
         write_enable_q <= 1'b0;
         write_data_q   <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         write_enable_q <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;

         if (state_q == ST_IDLE) begin
            // cmd_abort is meaningless here; a coincident start wins.
            if (cmd_start) begin
               if (cmd_len == '0) begin
                  err_q <= 1'b1;
               end else begin
                  rem_q      <= cmd_len;
                  sum_q      <= '0;
                  hold_vld_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_STREAM;
               end
            end
         end else if (cmd_abort) begin
            state_q    <= ST_IDLE;
            hold_vld_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            if (accept) begin
               hold_q     <= s_data;
               hold_vld_q <= 1'b1;
               rem_q      <= rem_q - LEN_W'(1);
               sum_q      <= sum_q + s_data;
            end

            if (push) begin
               write_enable_q <= 1'b1;
               write_data_q   <= hold_q;
               hold_vld_q     <= 1'b0;
               // rem_q==0 with a push means the last payload (or checksum) byte is leaving.
               if (rem_q == '0) begin
                  if ((state_q == ST_STREAM) && CHKSUM_EN) begin
                     hold_q     <= chksum_byte(sum_q);
                     hold_vld_q <= 1'b1;
                     state_q    <= ST_CHKSUM;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end

            if (state_q == ST_DONE) begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   assign write_enable = write_enable_q;
   assign write_data   = write_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Directed bench for i2c_tx_feeder: instance A with checksum, instance B without.
// Latency: n/a. Backpressure: fifo_full driven directly by the stimulus.
module tb_i2c_tx_feeder;

   logic       clk = 1'b0;
   logic       n_rst;

   logic       cmd_start, cmd_abort, s_valid, fifo_full;
   logic [7:0] cmd_len, s_data;
   logic       s_ready, write_enable, busy, done, err;
   logic [7:0] write_data;

   logic       b_cmd_start, b_cmd_abort, b_s_valid, b_fifo_full;
   logic [7:0] b_cmd_len, b_s_data;
   logic       b_s_ready, b_write_enable, b_busy, b_done, b_err;
   logic [7:0] b_write_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pushq_a[$];
   logic [7:0] pushq_b[$];
   int  consec_a = 0, consec_b = 0;
   int  done_cnt_a = 0, done_cnt_b = 0, err_cnt_a = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   always #5 clk = ~clk;

   i2c_tx_feeder #(.LEN_W(8), .CHKSUM_EN(1'b1)) dut_a (
      .clk(clk), .n_rst(n_rst),
      .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .fifo_full(fifo_full), .write_enable(write_enable), .write_data(write_data),
      .busy(busy), .done(done), .err(err)
   );

   i2c_tx_feeder #(.LEN_W(8), .CHKSUM_EN(1'b0)) dut_b (
      .clk(clk), .n_rst(n_rst),
      .cmd_start(b_cmd_start), .cmd_len(b_cmd_len), .cmd_abort(b_cmd_abort),
      .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
      .fifo_full(b_fifo_full), .write_enable(b_write_enable), .write_data(b_write_data),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   // Push/status monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (write_enable) pushq_a.push_back(write_data);
      if (write_enable && prev_a) consec_a++;
      prev_a = write_enable;
      if (done) done_cnt_a++;
      if (err)  err_cnt_a++;
      if (b_write_enable) pushq_b.push_back(b_write_data);
      if (b_write_enable && prev_b) consec_b++;
      prev_b = b_write_enable;
      if (b_done) done_cnt_b++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      pushq_a.delete(); pushq_b.delete();
      consec_a = 0; consec_b = 0;
      done_cnt_a = 0; done_cnt_b = 0; err_cnt_a = 0;
   endtask

   task automatic start_a(input logic [7:0] len);
      cmd_start = 1'b1; cmd_len = len;
      tick();
      cmd_start = 1'b0;
   endtask

   // Offers one byte; returns after the edge that accepted it, or ok=0 on timeout.
   task automatic send_byte(input bit sel, input logic [7:0] b, output bit ok);
      int n = 0;
      ok = 1'b0;
      if (sel) begin b_s_valid = 1'b1; b_s_data = b; end
      else     begin s_valid   = 1'b1; s_data   = b; end
      while (n < 60 && !ok) begin
         if (sel ? b_s_ready : s_ready) ok = 1'b1;
         tick();
         n++;
      end
      if (sel) b_s_valid = 1'b0; else s_valid = 1'b0;
   endtask

   task automatic wait_done_a(output bit ok);
      int n = 0;
      while (!done && n < 60) begin tick(); n++; end
      ok = done;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      cmd_start = 0; cmd_abort = 0; cmd_len = 0; s_valid = 0; s_data = 0; fifo_full = 0;
      b_cmd_start = 0; b_cmd_abort = 0; b_cmd_len = 0; b_s_valid = 0; b_s_data = 0; b_fifo_full = 0;
      #12;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", write_enable); end
      checks++; if (write_data !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h want 00", write_data); end
      checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_status: got %b want 000", {busy, done, err}); end
      n_rst = 1'b1;
      tick(); tick();
   endtask

   task automatic test_checksum_msg();
      bit ok;
      logic [7:0] exp[4] = '{8'h10, 8'h20, 8'h30, 8'hA0};
      logic [7:0] bytes[3] = '{8'h10, 8'h20, 8'h30};
      clear_mon();
      start_a(8'd3);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start: got %b want 1", busy); end
      for (int i = 0; i < 3; i++) begin
         send_byte(1'b0, bytes[i], ok);
         checks++; if (!ok) begin failures++; $display("FAIL basic_accept_%0d: timeout, byte %h not accepted", i, bytes[i]); end
      end
      wait_done_a(ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_done: got timeout want done pulse"); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_with_done: got %b want 1", busy); end
      tick();
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL basic_busy_after_done: got busy,done=%b want 00", {busy, done}); end
      tick(); tick();
      checks++; if (pushq_a.size() !== 4) begin failures++; $display("FAIL basic_push_count: got %0d want 4", pushq_a.size()); end
      for (int i = 0; i < 4 && i < pushq_a.size(); i++) begin
         checks++; if (pushq_a[i] !== exp[i]) begin failures++; $display("FAIL basic_push_%0d: got %h want %h", i, pushq_a[i], exp[i]); end
      end
      checks++; if (consec_a !== 0) begin failures++; $display("FAIL basic_gap: got %0d back-to-back pushes want 0", consec_a); end
      checks++; if (done_cnt_a !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt_a); end
   endtask

   task automatic test_fifo_full();
      bit ok;
      int bad = 0;
      logic [7:0] exp[3] = '{8'hFF, 8'h02, 8'hFF};
      clear_mon();
      start_a(8'd2);
      send_byte(1'b0, 8'hFF, ok);
      fifo_full = 1'b1;
      s_valid = 1'b1; s_data = 8'h02;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_ready !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) bad++;
      end
      s_valid = 1'b0;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_stall: got %0d cycles with s_ready/push/idle want 0", bad); end
      checks++; if (pushq_a.size() !== 0) begin failures++; $display("FAIL full_no_push: got %0d pushes want 0", pushq_a.size()); end
      fifo_full = 1'b0;
      send_byte(1'b0, 8'h02, ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_accept2: timeout want accept"); end
      wait_done_a(ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_done: got timeout want done pulse"); end
      tick(); tick();
      checks++; if (pushq_a.size() !== 3) begin failures++; $display("FAIL full_push_count: got %0d want 3", pushq_a.size()); end
      for (int i = 0; i < 3 && i < pushq_a.size(); i++) begin
         checks++; if (pushq_a[i] !== exp[i]) begin failures++; $display("FAIL full_push_%0d: got %h want %h", i, pushq_a[i], exp[i]); end
      end
   endtask

   task automatic test_zero_len();
      clear_mon();
      start_a(8'd0);
      checks++; if ({err, busy} !== 2'b10) begin failures++; $display("FAIL zero_err: got err,busy=%b want 10", {err, busy}); end
      tick();
      checks++; if ({err, busy} !== 2'b00) begin failures++; $display("FAIL zero_err_once: got err,busy=%b want 00", {err, busy}); end
      tick(); tick();
      checks++; if (err_cnt_a !== 1 || pushq_a.size() !== 0) begin failures++; $display("FAIL zero_counts: got err=%0d pushes=%0d want 1,0", err_cnt_a, pushq_a.size()); end
   endtask

   task automatic test_abort();
      bit ok;
      int n = 0;
      logic [7:0] exp[2] = '{8'h55, 8'hAB};
      clear_mon();
      start_a(8'd4);
      send_byte(1'b0, 8'h01, ok);
      send_byte(1'b0, 8'h02, ok);
      while (pushq_a.size() < 1 || !write_enable) begin
         if (n > 20) break;
         tick(); n++;
      end
      checks++; if (!write_enable) begin failures++; $display("FAIL abort_second_push: got timeout want second push"); end
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      checks++; if ({busy, write_enable, s_ready} !== 3'b000) begin failures++; $display("FAIL abort_idle: got busy,we,s_ready=%b want 000", {busy, write_enable, s_ready}); end
      for (int i = 0; i < 8; i++) tick();
      checks++; if (pushq_a.size() !== 2 || done_cnt_a !== 0) begin failures++; $display("FAIL abort_quiet: got pushes=%0d done=%0d want 2,0", pushq_a.size(), done_cnt_a); end
      clear_mon();
      start_a(8'd1);
      send_byte(1'b0, 8'h55, ok);
      wait_done_a(ok);
      checks++; if (!ok) begin failures++; $display("FAIL abort_restart_done: got timeout want done pulse"); end
      tick(); tick();
      checks++; if (pushq_a.size() !== 2) begin failures++; $display("FAIL abort_restart_count: got %0d want 2", pushq_a.size()); end
      for (int i = 0; i < 2 && i < pushq_a.size(); i++) begin
         checks++; if (pushq_a[i] !== exp[i]) begin failures++; $display("FAIL abort_restart_%0d: got %h want %h", i, pushq_a[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_mon();
      start_a(8'd3);
      send_byte(1'b0, 8'h77, ok);
      n_rst = 1'b0;
      #1;
      checks++; if ({busy, write_enable, s_ready, done, err} !== 5'b0) begin failures++; $display("FAIL rst_mid_outputs: got %b want 00000", {busy, write_enable, s_ready, done, err}); end
      checks++; if (write_data !== 8'h00) begin failures++; $display("FAIL rst_mid_wdata: got %h want 00", write_data); end
      #12;
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (pushq_a.size() !== 0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_quiet: got pushes=%0d busy=%b want 0,0", pushq_a.size(), busy); end
   endtask

   task automatic test_back_to_back_long();
      bit ok;
      int n = 0, bad = 0, tmo = 0;
      logic [7:0] exp[255];
      clear_mon();
      for (int i = 0; i < 255; i++) exp[i] = 8'($urandom_range(0, 255));
      b_cmd_start = 1'b1; b_cmd_len = 8'd255;
      tick();
      b_cmd_start = 1'b0;
      for (int i = 0; i < 255; i++) begin
         int gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         send_byte(1'b1, exp[i], ok);
         if (!ok) tmo++;
      end
      checks++; if (tmo !== 0) begin failures++; $display("FAIL long_accept: got %0d timeouts want 0", tmo); end
      while (!b_done && n < 60) begin tick(); n++; end
      checks++; if (!b_done) begin failures++; $display("FAIL long_done: got timeout want done pulse"); end
      tick(); tick(); tick();
      checks++; if (pushq_b.size() !== 255) begin failures++; $display("FAIL long_push_count: got %0d want 255", pushq_b.size()); end
      for (int i = 0; i < 255 && i < pushq_b.size(); i++) if (pushq_b[i] !== exp[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL long_order: got %0d mismatched bytes want 0", bad); end
      checks++; if (consec_b !== 0) begin failures++; $display("FAIL long_gap: got %0d back-to-back pushes want 0", consec_b); end
      checks++; if (done_cnt_b !== 1 || b_busy !== 1'b0) begin failures++; $display("FAIL long_done_once: got done=%0d busy=%b want 1,0", done_cnt_b, b_busy); end
   endtask

   initial begin
      test_reset();
      test_checksum_msg();
      test_fifo_full();
      test_zero_len();
      test_abort();
      test_reset_mid();
      test_back_to_back_long();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
